// File: rtl/dm_responder.sv
// Data-memory responder: captures one processor request at a time, waits a
// configurable number of cycles, then answers with a single-cycle ack.
module dm_responder #(
  parameter int MEM_DEPTH   = 128,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_data_in,
  input  logic [31:0] dm_wr_mask,
  input  logic        dm_wr_req,
  input  logic        dm_rd_req,
  output logic [31:0] dm_data_o,
  output logic        dm_ack,
  output logic        dm_err,
  output logic        busy
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [2:0] CNT_LOAD = 3'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [2:0]  cnt_reg, cnt_next;

  logic [31:0] addr_reg;
  logic [31:0] data_reg;
  logic [3:0]  mask_reg;
  logic        wr_reg;
  logic        err_reg;

  logic [31:0] cur_addr;
  logic [31:0] cur_data;
  logic [3:0]  cur_mask;
  logic        cur_wr;
  logic        cur_err;
  logic [IDX_W-1:0] cur_idx;

  logic        capture;
  logic        enter_resp;
  logic        wr_en;
  logic        rd_load;
  logic        err_load;

  // Only the low four mask bits carry byte enables.
  logic        unused_mask_bits;
  assign unused_mask_bits = ^dm_wr_mask[31:4];

  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> (IDX_W + 2)) != 32'd0);
  endfunction

  // In IDLE the live inputs are the request being captured this edge (needed
  // when WAIT_STATES=0); otherwise the latched copy is authoritative.
  always_comb begin
    cur_addr = addr_reg;
    cur_data = data_reg;
    cur_mask = mask_reg;
    cur_wr   = wr_reg;
    cur_err  = err_reg;
    if (state_reg == IDLE) begin
      cur_addr = dm_addr;
      cur_data = dm_data_in;
      cur_mask = dm_wr_mask[3:0];
      cur_wr   = dm_wr_req;
      cur_err  = addr_bad(dm_addr) || (dm_wr_req && dm_rd_req);
    end
  end

  assign cur_idx = cur_addr[IDX_W+1:2];

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (dm_wr_req || dm_rd_req) begin
          capture = 1'b1;
          if (WAIT_STATES > 0) begin
            state_next = WAIT;
            cnt_next   = CNT_LOAD;
          end else begin
            state_next = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_reg == 3'd0) begin
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg - 3'd1;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 3'd0;
      end
    endcase
  end

  // Memory and read-data updates happen on the edge that enters RESP, so a
  // reset sampled on that edge cancels both the ack and the write.
  assign enter_resp = rst && (state_next == RESP) && (state_reg != RESP);
  assign wr_en      = enter_resp && cur_wr && !cur_err;
  assign rd_load    = enter_resp && !cur_wr && !cur_err;
  assign err_load   = enter_resp && cur_err;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 3'd0;
      addr_reg  <= 32'd0;
      data_reg  <= 32'd0;
      mask_reg  <= 4'd0;
      wr_reg    <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (capture) begin
        addr_reg <= dm_addr;
        data_reg <= dm_data_in;
        mask_reg <= dm_wr_mask[3:0];
        wr_reg   <= dm_wr_req;
        err_reg  <= cur_err;
      end
    end
  end

  // One byte-wide RAM per lane so each lane's enable maps onto a plain
  // single-port array with a registered read.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [MEM_DEPTH];
      logic [7:0] rd_byte_reg;

      always_ff @(posedge clk) begin
        if (wr_en && cur_mask[gi]) begin
          mem[cur_idx] <= cur_data[8*gi +: 8];
        end
      end

      always_ff @(posedge clk) begin
        if (!rst) begin
          rd_byte_reg <= 8'd0;
        end else if (err_load) begin
          rd_byte_reg <= 8'd0;
        end else if (rd_load) begin
          rd_byte_reg <= mem[cur_idx];
        end
      end

      assign dm_data_o[8*gi +: 8] = rd_byte_reg;
    end
  endgenerate

  assign dm_ack = (state_reg == RESP);
  assign dm_err = (state_reg == RESP) && err_reg;
  assign busy   = (state_reg != IDLE);

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: a WAIT_STATES=1 instance driven from a
// vector table plus a WAIT_STATES=0 instance for back-to-back reads.
module tb_dm_responder;

  logic        clk;
  logic        rst;

  logic [31:0] dm_addr, dm_data_in, dm_wr_mask;
  logic        dm_wr_req, dm_rd_req;
  logic [31:0] dm_data_o;
  logic        dm_ack, dm_err, busy;

  logic [31:0] z_addr, z_data_in, z_wr_mask;
  logic        z_wr_req, z_rd_req;
  logic [31:0] z_data_o;
  logic        z_ack, z_err, z_busy;

  int n_checks;
  int n_fail;

  dm_responder #(.MEM_DEPTH(128), .WAIT_STATES(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .dm_addr    (dm_addr),
    .dm_data_in (dm_data_in),
    .dm_wr_mask (dm_wr_mask),
    .dm_wr_req  (dm_wr_req),
    .dm_rd_req  (dm_rd_req),
    .dm_data_o  (dm_data_o),
    .dm_ack     (dm_ack),
    .dm_err     (dm_err),
    .busy       (busy)
  );

  dm_responder #(.MEM_DEPTH(128), .WAIT_STATES(0)) dut_ws0 (
    .clk        (clk),
    .rst        (rst),
    .dm_addr    (z_addr),
    .dm_data_in (z_data_in),
    .dm_wr_mask (z_wr_mask),
    .dm_wr_req  (z_wr_req),
    .dm_rd_req  (z_rd_req),
    .dm_data_o  (z_data_o),
    .dm_ack     (z_ack),
    .dm_err     (z_err),
    .busy       (z_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic        exp_err;
    logic [31:0] exp_data;
  } vec_t;

  localparam int NVEC = 22;
  vec_t tbl [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called at a falling edge with the DUT idle; returns at a falling edge one
  // cycle after the ack, so the next request is sampled in plain IDLE.
  task automatic run_txn(input string tag, input vec_t v);
    int   cyc;
    logic got;
    dm_wr_req  = v.wr;
    dm_rd_req  = v.rd;
    dm_addr    = v.addr;
    dm_data_in = v.data;
    dm_wr_mask = {28'd0, v.mask};
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (dm_ack) got = 1'b1;
    end
    check({tag, "_latency"}, 32'(cyc), 32'd2);
    if (got) begin
      check({tag, "_err"},  {31'd0, dm_err}, {31'd0, v.exp_err});
      check({tag, "_data"}, dm_data_o, v.exp_data);
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    end
    dm_wr_req = 1'b0;
    dm_rd_req = 1'b0;
    @(negedge clk);
    check({tag, "_ack_pulse"}, {31'd0, dm_ack}, 32'd0);
    $display("txn %s wr=%0b rd=%0b addr=%h data_in=%h mask=%h -> ack_cycles=%0d err=%0b data_o=%h",
             tag, v.wr, v.rd, v.addr, v.data, v.mask, cyc, dm_err, dm_data_o);
  endtask

  initial begin
    logic ack_seen;
    n_checks = 0;
    n_fail   = 0;

    //          wr    rd    addr          data          mask  err   exp_data
    tbl[0]  = '{1'b1, 1'b0, 32'h0000_0008, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0000_0000};
    tbl[1]  = '{1'b0, 1'b1, 32'h0000_0008, 32'h0,         4'h0, 1'b0, 32'hDEAD_BEEF};
    tbl[2]  = '{1'b1, 1'b0, 32'h0000_0008, 32'h1122_3344, 4'h5, 1'b0, 32'hDEAD_BEEF};
    tbl[3]  = '{1'b0, 1'b1, 32'h0000_0008, 32'h0,         4'h0, 1'b0, 32'hDE22_BE44};
    tbl[4]  = '{1'b1, 1'b0, 32'h0000_000C, 32'h1234_5678, 4'hF, 1'b0, 32'hDE22_BE44};
    tbl[5]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0101_0101, 4'hF, 1'b0, 32'hDE22_BE44};
    tbl[6]  = '{1'b0, 1'b1, 32'h0000_000A, 32'h0,         4'h0, 1'b1, 32'h0000_0000};
    tbl[7]  = '{1'b0, 1'b1, 32'h0000_0200, 32'h0,         4'h0, 1'b1, 32'h0000_0000};
    tbl[8]  = '{1'b1, 1'b1, 32'h0000_000C, 32'hAAAA_AAAA, 4'hF, 1'b1, 32'h0000_0000};
    tbl[9]  = '{1'b1, 1'b0, 32'h0000_000A, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0000_0000};
    tbl[10] = '{1'b1, 1'b0, 32'h0000_0200, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0000_0000};
    tbl[11] = '{1'b0, 1'b1, 32'h0000_000C, 32'h0,         4'h0, 1'b0, 32'h1234_5678};
    tbl[12] = '{1'b0, 1'b1, 32'h0000_0008, 32'h0,         4'h0, 1'b0, 32'hDE22_BE44};
    tbl[13] = '{1'b0, 1'b1, 32'h0000_0000, 32'h0,         4'h0, 1'b0, 32'h0101_0101};
    tbl[14] = '{1'b1, 1'b0, 32'h0000_0008, 32'hFFFF_FFFF, 4'h0, 1'b0, 32'h0101_0101};
    tbl[15] = '{1'b0, 1'b1, 32'h0000_0008, 32'h0,         4'h0, 1'b0, 32'hDE22_BE44};
    tbl[16] = '{1'b1, 1'b0, 32'h0000_01FC, 32'hA5A5_A5A5, 4'hF, 1'b0, 32'hDE22_BE44};
    tbl[17] = '{1'b0, 1'b1, 32'h0000_01FC, 32'h0,         4'h0, 1'b0, 32'hA5A5_A5A5};
    tbl[18] = '{1'b1, 1'b0, 32'h0000_000C, 32'h7700_0000, 4'h8, 1'b0, 32'hA5A5_A5A5};
    tbl[19] = '{1'b0, 1'b1, 32'h0000_000C, 32'h0,         4'h0, 1'b0, 32'h7734_5678};
    tbl[20] = '{1'b0, 1'b1, 32'h8000_0008, 32'h0,         4'h0, 1'b1, 32'h0000_0000};
    tbl[21] = '{1'b0, 1'b1, 32'h0000_000C, 32'h0,         4'h0, 1'b0, 32'h7734_5678};

    rst = 1'b0;
    dm_addr = '0; dm_data_in = '0; dm_wr_mask = '0; dm_wr_req = 1'b0; dm_rd_req = 1'b0;
    z_addr  = '0; z_data_in  = '0; z_wr_mask  = '0; z_wr_req  = 1'b0; z_rd_req  = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_ack",     {31'd0, dm_ack}, 32'd0);
    check("reset_err",     {31'd0, dm_err}, 32'd0);
    check("reset_busy",    {31'd0, busy},   32'd0);
    check("reset_data",    dm_data_o,       32'd0);
    check("reset_ws0_ack", {31'd0, z_ack},  32'd0);
    check("reset_ws0_busy",{31'd0, z_busy}, 32'd0);
    check("reset_ws0_data",z_data_o,        32'd0);
    $display("txn reset ack=%0b err=%0b busy=%0b data_o=%h", dm_ack, dm_err, busy, dm_data_o);

    // The first request goes up together with reset release.
    rst = 1'b1;
    for (int i = 0; i < NVEC; i++) begin
      run_txn($sformatf("row%0d", i), tbl[i]);
    end

    // Reset sampled on the edge that would enter RESP: no ack, no write.
    dm_wr_req  = 1'b1;
    dm_addr    = 32'h0000_000C;
    dm_data_in = 32'hCAFE_F00D;
    dm_wr_mask = 32'h0000_000F;
    @(negedge clk);
    check("midrst_busy_wait", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    dm_wr_req = 1'b0;
    ack_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (dm_ack) ack_seen = 1'b1;
    end
    check("midrst_no_ack", {31'd0, ack_seen}, 32'd0);
    check("midrst_err",    {31'd0, dm_err},   32'd0);
    check("midrst_busy",   {31'd0, busy},     32'd0);
    check("midrst_data",   dm_data_o,         32'd0);
    $display("txn midreset ack_seen=%0b busy=%0b data_o=%h", ack_seen, busy, dm_data_o);
    rst = 1'b1;
    run_txn("midrst_read", '{1'b0, 1'b1, 32'h0000_000C, 32'h0, 4'h0, 1'b0, 32'h7734_5678});

    // Zero-wait instance: one write, then a held read alternating RESP/IDLE.
    z_wr_req  = 1'b1;
    z_addr    = 32'h0000_0008;
    z_data_in = 32'h5A5A_1234;
    z_wr_mask = 32'h0000_000F;
    @(negedge clk);
    check("ws0_wr_ack", {31'd0, z_ack}, 32'd1);
    check("ws0_wr_err", {31'd0, z_err}, 32'd0);
    $display("txn ws0_write addr=%h data_in=%h ack=%0b err=%0b", z_addr, z_data_in, z_ack, z_err);
    z_wr_req = 1'b0;
    @(negedge clk);
    check("ws0_wr_ack_pulse", {31'd0, z_ack}, 32'd0);

    z_rd_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("ws0_b2b%0d_ack", i),  {31'd0, z_ack},  (i % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("ws0_b2b%0d_busy", i), {31'd0, z_busy}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("ws0_b2b%0d_data", i), z_data_o, 32'h5A5A_1234);
      $display("txn ws0_b2b%0d ack=%0b busy=%0b err=%0b data_o=%h", i, z_ack, z_busy, z_err, z_data_o);
    end
    z_rd_req = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
